// File: rtl/decode_exec.sv
// Multi-cycle RV32I decode/execute stage: IDLE -> DECODE -> EXEC -> DONE, one instruction in flight.
// Optional macro MUL_EN enables the M-extension multiply group (MUL/MULH/MULHSU/MULHU).
module decode_exec #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      rs1_num,
    output logic [4:0]      rs2_num,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic            wb_reg,
    output logic [4:0]      rd_num,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] rs2,
    output logic            branch_taken,
    output logic [XLEN-1:0] next_pc,
    output logic            illegal,
    output logic            done
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    state_t          state, state_nxt;
    logic [XLEN-1:0] ir, pcr, a_q, b_q, imm_q, imm;
    logic [XLEN-1:0] op_b, alu_r, res, npc;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rd, shamt;
    logic            alt, wb, taken, ill, cond;

    assign opc     = ir[6:0];
    assign f3      = ir[14:12];
    assign f7      = ir[31:25];
    assign rd      = ir[11:7];
    assign rs1_num = ir[19:15];
    assign rs2_num = ir[24:20];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (opc)
            OP_LUI, OP_AUIPC: imm = {ir[31:12], 12'b0};
            OP_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            OP_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            default:   imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // Only SUB/SRA/SRAI use the alternate encoding; ADDI's upper immediate bits must not subtract.
    assign op_b  = (opc == OP_REG) ? b_q : imm_q;
    assign shamt = op_b[4:0];
    assign alt   = f7[5] && ((opc == OP_REG) || (f3 == 3'b101));

    always_comb begin
        case (f3)
            3'b000:  alu_r = alt ? a_q - op_b : a_q + op_b;
            3'b001:  alu_r = a_q << shamt;
            3'b010:  alu_r = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(op_b)};
            3'b011:  alu_r = {{(XLEN-1){1'b0}}, a_q < op_b};
            3'b100:  alu_r = a_q ^ op_b;
            3'b101:  alu_r = alt ? XLEN'($signed(a_q) >>> shamt) : a_q >> shamt;
            3'b110:  alu_r = a_q | op_b;
            default: alu_r = a_q & op_b;
        endcase
    end

`ifdef MUL_EN
    logic [XLEN:0]     mul_a, mul_b;
    logic [2*XLEN-1:0] prod;
    // 33-bit operands carry signedness so one signed multiplier covers all four variants.
    assign mul_a = {a_q[XLEN-1] & (f3 != 3'b011), a_q};
    assign mul_b = {b_q[XLEN-1] & ~f3[1], b_q};
    assign prod  = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};
`endif

    always_comb begin
        cond = 1'b0;
        case (f3)
            3'b000:  cond = (a_q == b_q);
            3'b001:  cond = (a_q != b_q);
            3'b100:  cond = ($signed(a_q) <  $signed(b_q));
            3'b101:  cond = ($signed(a_q) >= $signed(b_q));
            3'b110:  cond = (a_q <  b_q);
            3'b111:  cond = (a_q >= b_q);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        res   = '0;
        wb    = 1'b0;
        taken = 1'b0;
        ill   = 1'b0;
        npc   = pcr + 32'd4;
        case (opc)
            OP_LUI:   begin res = imm_q;       wb = 1'b1; end
            OP_AUIPC: begin res = pcr + imm_q; wb = 1'b1; end
            OP_JAL: begin
                res = pcr + 32'd4; npc = pcr + imm_q; taken = 1'b1; wb = 1'b1;
            end
            OP_JALR: begin
                ill = (f3 != 3'b000);
                res = pcr + 32'd4; npc = (a_q + imm_q) & ~32'd1; taken = 1'b1; wb = 1'b1;
            end
            OP_BRANCH: begin
                ill = (f3[2:1] == 2'b01);
                if (cond) begin
                    taken = 1'b1;
                    npc   = pcr + imm_q;
                end
            end
            OP_LOAD: begin
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                res = a_q + imm_q; wb = 1'b1;
            end
            OP_STORE: begin
                ill = f3[2] || (f3[1:0] == 2'b11);
                res = a_q + imm_q;
            end
            OP_IMM: begin
                if (f3 == 3'b001)      ill = (f7 != 7'b0000000);
                else if (f3 == 3'b101) ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                res = alu_r; wb = 1'b1;
            end
            OP_REG: begin
                wb = 1'b1;
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    res = alu_r;
                end else if (f7 == 7'b0000001) begin
`ifdef MUL_EN
                    ill = f3[2];
                    res = (f3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`else
                    ill = 1'b1;
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            OP_FENCE: ;
            default:  ill = 1'b1;
        endcase
        if (ill) begin
            res   = '0;
            wb    = 1'b0;
            taken = 1'b0;
            npc   = pcr + 32'd4;
        end
        if (rd == 5'd0) wb = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir           <= NOP_INST;
            pcr          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            opcode       <= '0;
            func3        <= '0;
            rd_num       <= '0;
            alu_out      <= '0;
            rs2          <= '0;
            wb_reg       <= 1'b0;
            branch_taken <= 1'b0;
            next_pc      <= '0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ir  <= inst;
                    pcr <= pc;
                end
                S_DECODE: begin
                    a_q   <= rs1_data;
                    b_q   <= rs2_data;
                    imm_q <= imm;
                end
                S_EXEC: begin
                    opcode       <= opc;
                    func3        <= f3;
                    rd_num       <= rd;
                    alu_out      <= res;
                    rs2          <= b_q;
                    wb_reg       <= wb;
                    branch_taken <= taken;
                    next_pc      <= npc;
                    illegal      <= ill;
                end
                default: ;
            endcase
        end
    end

endmodule
